// File: rtl/axi_pkg.sv
// Shared types and constants for the cache-side AXI4-Lite master.
package axi_pkg;

  typedef enum logic [1:0] {
    OKAY   = 2'b00,
    EXOKAY = 2'b01,
    SLVERR = 2'b10,
    DECERR = 2'b11
  } axi_resp_t;

  typedef enum logic [2:0] {
    IDLE,
    WR_REQ,
    WR_RESP,
    RD_ADDR,
    RD_DATA,
    COMPLETE
  } axi_ctrl_state_t;

  // Encoding of the cache write-size request field
  localparam logic [1:0] WR_NONE = 2'd0;
  localparam logic [1:0] WR_BYTE = 2'd1;
  localparam logic [1:0] WR_HALF = 2'd2;
  localparam logic [1:0] WR_WORD = 2'd3;

endpackage

// File: rtl/axi_controller_if.sv
// Cache <-> AXI controller request/completion handshake.
interface axi_controller_if;
  logic        read;
  logic [1:0]  write;
  logic [31:0] addr;
  logic [31:0] store;
  logic        done;
  logic        ready;
  logic [31:0] load;

  modport axi_controller (
    input  read, write, addr, store, done,
    output ready, load
  );

  modport cache (
    output read, write, addr, store, done,
    input  ready, load
  );
endinterface

// File: rtl/axi_store_align.sv
// Places store data on the byte lanes selected by the write size and the
// low address bits, and flags writes that do not fit their natural alignment.
module axi_store_align
  import axi_pkg::*;
(
  input  logic [1:0]  write,
  input  logic [1:0]  addr_lo,
  input  logic [31:0] store,
  output logic [31:0] wdata,
  output logic [3:0]  wstrb,
  output logic        misaligned
);

  // Lane replication and strobe generation per write size
  always_comb begin
    wdata      = store;
    wstrb      = 4'b0000;
    misaligned = 1'b0;
    case (write)
      WR_BYTE: begin
        wdata = {4{store[7:0]}};
        wstrb = 4'b0001 << addr_lo;
      end
      WR_HALF: begin
        wdata      = {2{store[15:0]}};
        wstrb      = 4'b0011 << addr_lo;
        misaligned = addr_lo[0];
      end
      WR_WORD: begin
        wdata      = store;
        wstrb      = 4'b1111;
        misaligned = |addr_lo;
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/axi_controller.sv
// AXI4-Lite master serving single-word cache requests, one at a time.
//
// state    | meaning
// ---------+-----------------------------------------------------------
// IDLE     | waiting for a cache request (write wins over read)
// WR_REQ   | AWVALID/WVALID raised, each dropped after its own handshake
// WR_RESP  | BREADY raised, waiting for the write response
// RD_ADDR  | ARVALID raised, waiting for ARREADY
// RD_DATA  | RREADY raised, waiting for read data
// COMPLETE | ready to cache with load/bus_err held until done or withdraw
module axi_controller
  import axi_pkg::*;
#(
  parameter logic [2:0] AWPROT_VAL = 3'b000,
  parameter logic [2:0] ARPROT_VAL = 3'b000
) (
  input  logic                        clk,
  input  logic                        rst,
  axi_controller_if.axi_controller    amif,
  output logic                        bus_err,
  output logic [31:0]                 m_awaddr,
  output logic [2:0]                  m_awprot,
  output logic                        m_awvalid,
  input  logic                        m_awready,
  output logic [31:0]                 m_wdata,
  output logic [3:0]                  m_wstrb,
  output logic                        m_wvalid,
  input  logic                        m_wready,
  input  logic [1:0]                  m_bresp,
  input  logic                        m_bvalid,
  output logic                        m_bready,
  output logic [31:0]                 m_araddr,
  output logic [2:0]                  m_arprot,
  output logic                        m_arvalid,
  input  logic                        m_arready,
  input  logic [31:0]                 m_rdata,
  input  logic [1:0]                  m_rresp,
  input  logic                        m_rvalid,
  output logic                        m_rready
);

  axi_ctrl_state_t state_q, state_d;
  logic [31:0] awaddr_q, awaddr_d;
  logic [31:0] wdata_q, wdata_d;
  logic [3:0]  wstrb_q, wstrb_d;
  logic [31:0] araddr_q, araddr_d;
  logic        awvalid_q, awvalid_d;
  logic        wvalid_q, wvalid_d;
  logic        bready_q, bready_d;
  logic        arvalid_q, arvalid_d;
  logic        rready_q, rready_d;
  logic        ready_q, ready_d;
  logic [31:0] load_q, load_d;
  logic        bus_err_q, bus_err_d;

  logic [31:0] al_wdata;
  logic [3:0]  al_wstrb;
  logic        al_misaligned;
  logic        aw_done;
  logic        w_done;

  axi_store_align u_store_align (
    .write      (amif.write),
    .addr_lo    (amif.addr[1:0]),
    .store      (amif.store),
    .wdata      (al_wdata),
    .wstrb      (al_wstrb),
    .misaligned (al_misaligned)
  );

  // A write channel is finished once its valid is low or handshaking now
  assign aw_done = !awvalid_q || m_awready;
  assign w_done  = !wvalid_q  || m_wready;

  // Next-state and registered-output computation
  always_comb begin
    state_d   = state_q;
    awaddr_d  = awaddr_q;
    wdata_d   = wdata_q;
    wstrb_d   = wstrb_q;
    araddr_d  = araddr_q;
    awvalid_d = awvalid_q;
    wvalid_d  = wvalid_q;
    bready_d  = bready_q;
    arvalid_d = arvalid_q;
    rready_d  = rready_q;
    ready_d   = ready_q;
    load_d    = load_q;
    bus_err_d = bus_err_q;

    case (state_q)
      IDLE: begin
        if (amif.write != WR_NONE) begin
          if (al_misaligned) begin
            ready_d   = 1'b1;
            bus_err_d = 1'b1;
            state_d   = COMPLETE;
          end else begin
            awaddr_d  = {amif.addr[31:2], 2'b00};
            wdata_d   = al_wdata;
            wstrb_d   = al_wstrb;
            awvalid_d = 1'b1;
            wvalid_d  = 1'b1;
            state_d   = WR_REQ;
          end
        end else if (amif.read) begin
          araddr_d  = {amif.addr[31:2], 2'b00};
          arvalid_d = 1'b1;
          state_d   = RD_ADDR;
        end
      end
      WR_REQ: begin
        if (awvalid_q && m_awready) awvalid_d = 1'b0;
        if (wvalid_q && m_wready)   wvalid_d  = 1'b0;
        if (aw_done && w_done) begin
          bready_d = 1'b1;
          state_d  = WR_RESP;
        end
      end
      WR_RESP: begin
        if (m_bvalid) begin
          bready_d  = 1'b0;
          bus_err_d = (axi_resp_t'(m_bresp) != OKAY);
          ready_d   = 1'b1;
          state_d   = COMPLETE;
        end
      end
      RD_ADDR: begin
        if (m_arready) begin
          arvalid_d = 1'b0;
          rready_d  = 1'b1;
          state_d   = RD_DATA;
        end
      end
      RD_DATA: begin
        if (m_rvalid) begin
          rready_d  = 1'b0;
          load_d    = m_rdata;
          bus_err_d = (axi_resp_t'(m_rresp) != OKAY);
          ready_d   = 1'b1;
          state_d   = COMPLETE;
        end
      end
      COMPLETE: begin
        if (amif.done || (!amif.read && amif.write == WR_NONE)) begin
          ready_d   = 1'b0;
          bus_err_d = 1'b0;
          state_d   = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State and output registers with synchronous reset
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      awaddr_q  <= '0;
      wdata_q   <= '0;
      wstrb_q   <= '0;
      araddr_q  <= '0;
      awvalid_q <= 1'b0;
      wvalid_q  <= 1'b0;
      bready_q  <= 1'b0;
      arvalid_q <= 1'b0;
      rready_q  <= 1'b0;
      ready_q   <= 1'b0;
      load_q    <= '0;
      bus_err_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      awaddr_q  <= awaddr_d;
      wdata_q   <= wdata_d;
      wstrb_q   <= wstrb_d;
      araddr_q  <= araddr_d;
      awvalid_q <= awvalid_d;
      wvalid_q  <= wvalid_d;
      bready_q  <= bready_d;
      arvalid_q <= arvalid_d;
      rready_q  <= rready_d;
      ready_q   <= ready_d;
      load_q    <= load_d;
      bus_err_q <= bus_err_d;
    end
  end

  assign amif.ready = ready_q;
  assign amif.load  = load_q;
  assign bus_err    = bus_err_q;
  assign m_awaddr   = awaddr_q;
  assign m_awprot   = AWPROT_VAL;
  assign m_awvalid  = awvalid_q;
  assign m_wdata    = wdata_q;
  assign m_wstrb    = wstrb_q;
  assign m_wvalid   = wvalid_q;
  assign m_bready   = bready_q;
  assign m_araddr   = araddr_q;
  assign m_arprot   = ARPROT_VAL;
  assign m_arvalid  = arvalid_q;
  assign m_rready   = rready_q;

endmodule

// File: tb/tb_axi_controller.sv
// Bench for axi_controller: delay-configurable AXI4-Lite slave, cache-side
// driver and a transaction-level expectation model.
module tb_axi_controller;
  import axi_pkg::*;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  axi_controller_if amif ();

  logic        bus_err;
  logic [31:0] m_awaddr, m_wdata, m_araddr, m_rdata;
  logic [2:0]  m_awprot, m_arprot;
  logic [3:0]  m_wstrb;
  logic        m_awvalid, m_wvalid, m_bready, m_arvalid, m_rready;
  logic        s_awready, s_wready, s_bvalid, s_arready, s_rvalid;
  logic [1:0]  s_bresp, s_rresp;

  axi_controller #(.AWPROT_VAL(3'b000), .ARPROT_VAL(3'b000)) dut (
    .clk       (clk),
    .rst       (rst),
    .amif      (amif),
    .bus_err   (bus_err),
    .m_awaddr  (m_awaddr),
    .m_awprot  (m_awprot),
    .m_awvalid (m_awvalid),
    .m_awready (s_awready),
    .m_wdata   (m_wdata),
    .m_wstrb   (m_wstrb),
    .m_wvalid  (m_wvalid),
    .m_wready  (s_wready),
    .m_bresp   (s_bresp),
    .m_bvalid  (s_bvalid),
    .m_bready  (m_bready),
    .m_araddr  (m_araddr),
    .m_arprot  (m_arprot),
    .m_arvalid (m_arvalid),
    .m_arready (s_arready),
    .m_rdata   (m_rdata),
    .m_rresp   (s_rresp),
    .m_rvalid  (s_rvalid),
    .m_rready  (m_rready)
  );

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Slave configuration, written by the stimulus process only
  int          cfg_aw_dly = 0, cfg_w_dly = 0, cfg_b_dly = 0, cfg_ar_dly = 0, cfg_r_dly = 0;
  logic [1:0]  cfg_bresp = 2'b00, cfg_rresp = 2'b00;
  logic [31:0] cfg_rdata = '0;

  // Slave state and observation, written by the slave process only
  int          aw_cnt = 0, w_cnt = 0, b_cnt = 0, ar_cnt = 0, r_cnt = 0;
  bit          aw_done_s = 0, w_done_s = 0, b_done_s = 0, ar_done_s = 0, r_done_s = 0;
  bit          p_awv = 0, p_wv = 0, p_arv = 0, p_bready = 0, p_rready = 0;
  int          n_aw = 0, n_w = 0, n_b = 0, n_ar = 0, n_r = 0, hold_viol = 0;
  logic [31:0] cap_awaddr = '0, cap_wdata = '0, cap_araddr = '0, s_rdata = '0;
  logic [3:0]  cap_wstrb = '0;

  assign m_rdata = s_rdata;

  // Slave: acts on falling edges, so its outputs are stable at each rising edge
  always @(negedge clk) begin : slave
    bit hs_aw, hs_w, hs_b, hs_ar, hs_r, aw_now, w_now, ar_now;
    if (rst) begin
      s_awready <= 0; s_wready <= 0; s_bvalid <= 0; s_arready <= 0; s_rvalid <= 0;
      s_bresp <= 0; s_rresp <= 0;
      aw_cnt <= 0; w_cnt <= 0; b_cnt <= 0; ar_cnt <= 0; r_cnt <= 0;
      aw_done_s <= 0; w_done_s <= 0; b_done_s <= 0; ar_done_s <= 0; r_done_s <= 0;
    end else begin
      hs_aw = p_awv && s_awready;
      hs_w  = p_wv && s_wready;
      hs_ar = p_arv && s_arready;
      hs_b  = s_bvalid && p_bready;
      hs_r  = s_rvalid && p_rready;
      if (hs_aw) begin n_aw <= n_aw + 1; cap_awaddr <= m_awaddr; end
      if (hs_w)  begin n_w <= n_w + 1; cap_wdata <= m_wdata; cap_wstrb <= m_wstrb; end
      if (hs_ar) begin n_ar <= n_ar + 1; cap_araddr <= m_araddr; end
      if (hs_b)  n_b <= n_b + 1;
      if (hs_r)  n_r <= n_r + 1;
      if ((p_awv && !s_awready && !m_awvalid) || (p_wv && !s_wready && !m_wvalid) ||
          (p_arv && !s_arready && !m_arvalid))
        hold_viol <= hold_viol + 1;
      aw_now = aw_done_s || hs_aw;
      w_now  = w_done_s || hs_w;
      ar_now = ar_done_s || hs_ar;
      if (amif.ready) begin
        s_awready <= 0; s_wready <= 0; s_bvalid <= 0; s_arready <= 0; s_rvalid <= 0;
        aw_cnt <= 0; w_cnt <= 0; b_cnt <= 0; ar_cnt <= 0; r_cnt <= 0;
        aw_done_s <= 0; w_done_s <= 0; b_done_s <= 0; ar_done_s <= 0; r_done_s <= 0;
      end else begin
        aw_done_s <= aw_now;
        w_done_s  <= w_now;
        ar_done_s <= ar_now;
        if (m_awvalid) begin
          if (aw_cnt >= cfg_aw_dly) s_awready <= 1;
          else begin s_awready <= 0; aw_cnt <= aw_cnt + 1; end
        end else begin s_awready <= 0; aw_cnt <= 0; end
        if (m_wvalid) begin
          if (w_cnt >= cfg_w_dly) s_wready <= 1;
          else begin s_wready <= 0; w_cnt <= w_cnt + 1; end
        end else begin s_wready <= 0; w_cnt <= 0; end
        if (m_arvalid) begin
          if (ar_cnt >= cfg_ar_dly) s_arready <= 1;
          else begin s_arready <= 0; ar_cnt <= ar_cnt + 1; end
        end else begin s_arready <= 0; ar_cnt <= 0; end
        if (hs_b) begin
          s_bvalid <= 0; b_done_s <= 1;
        end else if (aw_now && w_now && !b_done_s && !s_bvalid) begin
          if (b_cnt >= cfg_b_dly) begin s_bvalid <= 1; s_bresp <= cfg_bresp; end
          else b_cnt <= b_cnt + 1;
        end
        if (hs_r) begin
          s_rvalid <= 0; r_done_s <= 1;
        end else if (ar_now && !r_done_s && !s_rvalid) begin
          if (r_cnt >= cfg_r_dly) begin s_rvalid <= 1; s_rresp <= cfg_rresp; s_rdata <= cfg_rdata; end
          else r_cnt <= r_cnt + 1;
        end
      end
    end
    p_awv    <= m_awvalid;
    p_wv     <= m_wvalid;
    p_arv    <= m_arvalid;
    p_bready <= m_bready;
    p_rready <= m_rready;
  end

  logic [31:0] exp_load = '0;

  // One cache request end to end; expectations come from the request itself
  task automatic run_txn(input bit rd, input logic [1:0] wr, input logic [31:0] addr,
                         input logic [31:0] store, input int awd, input int wd, input int bd,
                         input int ard, input int rdly, input logic [1:0] bresp,
                         input logic [1:0] rresp, input logic [31:0] rdata,
                         input int hold, input bit withdraw);
    int nbytes, e_lat, lat, bad;
    int b_aw, b_w, b_b, b_ar, b_r, b_viol;
    bit is_wr, mis, e_err;
    logic [31:0] e_wdata;
    logic [3:0]  e_wstrb;
    logic [39:0] e_hs;
    cfg_aw_dly = awd; cfg_w_dly = wd; cfg_b_dly = bd; cfg_ar_dly = ard; cfg_r_dly = rdly;
    cfg_bresp = bresp; cfg_rresp = rresp; cfg_rdata = rdata;
    is_wr  = (wr != 2'd0);
    nbytes = (wr == 2'd1) ? 1 : (wr == 2'd2) ? 2 : 4;
    mis    = is_wr && ((addr % nbytes) != 0);
    e_wstrb = 4'(((1 << nbytes) - 1) << addr[1:0]);
    e_wdata = (nbytes == 1) ? 32'(addr[31:0] & 32'h0) + (32'(store[7:0]) * 32'h0101_0101) :
              (nbytes == 2) ? 32'(store[15:0]) * 32'h0001_0001 : store;
    if (mis)        e_lat = 1;
    else if (is_wr) e_lat = 3 + ((awd > wd) ? awd : wd) + bd;
    else            e_lat = 3 + ard + rdly;
    e_err = mis || (is_wr ? (bresp != 2'b00) : (rresp != 2'b00));
    if (!is_wr) exp_load = rdata;
    if (mis)        e_hs = {8'd0, 8'd0, 8'd0, 8'd0, 8'd0};
    else if (is_wr) e_hs = {8'd1, 8'd1, 8'd1, 8'd0, 8'd0};
    else            e_hs = {8'd0, 8'd0, 8'd0, 8'd1, 8'd1};
    b_aw = n_aw; b_w = n_w; b_b = n_b; b_ar = n_ar; b_r = n_r; b_viol = hold_viol;

    amif.read = rd; amif.write = wr; amif.addr = addr; amif.store = store; amif.done = 1'b0;
    lat = 0;
    while (!amif.ready && lat < 100) begin
      @(negedge clk);
      lat++;
    end
    check_eq("latency", 64'(lat), 64'(e_lat));
    check_eq("bus_err", 64'(bus_err), 64'(e_err));
    check_eq("load", 64'(amif.load), 64'(exp_load));
    bad = 0;
    repeat (hold) begin
      @(negedge clk);
      if (!amif.ready || bus_err !== e_err || amif.load !== exp_load) bad++;
    end
    check_eq("hold_stable", 64'(bad), 64'd0);
    if (withdraw) begin
      amif.read = 1'b0; amif.write = 2'd0;
    end else begin
      amif.done = 1'b1;
    end
    @(negedge clk);
    amif.done = 1'b0; amif.read = 1'b0; amif.write = 2'd0;
    check_eq("ready_drop", 64'({amif.ready, bus_err}), 64'd0);
    @(negedge clk);
    check_eq("idle_quiet", 64'({m_awvalid, m_wvalid, m_bready, m_arvalid, m_rready, amif.ready}), 64'd0);
    check_eq("hs_counts", 64'({8'(n_aw - b_aw), 8'(n_w - b_w), 8'(n_b - b_b), 8'(n_ar - b_ar), 8'(n_r - b_r)}), 64'(e_hs));
    check_eq("valid_hold", 64'(hold_viol - b_viol), 64'd0);
    if (is_wr && !mis) begin
      check_eq("awaddr", 64'(cap_awaddr), 64'(addr & 32'hFFFF_FFFC));
      check_eq("wdata", 64'(cap_wdata), 64'(e_wdata));
      check_eq("wstrb", 64'(cap_wstrb), 64'(e_wstrb));
    end else if (!is_wr) begin
      check_eq("araddr", 64'(cap_araddr), 64'(addr & 32'hFFFF_FFFC));
    end
  endtask

  initial begin : watchdog
    #300000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin : stim
    int waited;
    logic [1:0] wr, bresp, rresp;
    bit rd;
    rst = 1'b1;
    amif.read = 1'b0; amif.write = 2'd0; amif.addr = '0; amif.store = '0; amif.done = 1'b0;
    repeat (3) @(negedge clk);
    check_eq("rst_valids", 64'({m_awvalid, m_wvalid, m_bready, m_arvalid, m_rready}), 64'd0);
    check_eq("rst_ready", 64'({amif.ready, bus_err}), 64'd0);
    check_eq("rst_load", 64'(amif.load), 64'd0);
    check_eq("rst_regs", 64'({m_awaddr, m_araddr} | {m_wdata, 28'd0, m_wstrb}), 64'd0);
    check_eq("prot", 64'({m_awprot, m_arprot}), 64'd0);
    rst = 1'b0;
    @(negedge clk);

    run_txn(1, 2'd0, 32'h0000_1006, 32'h0, 0, 0, 0, 0, 0, 2'b00, 2'b00, 32'hDEAD_BEEF, 0, 0);
    run_txn(0, 2'd1, 32'h0000_0103, 32'h0000_00A5, 0, 3, 0, 0, 0, 2'b00, 2'b00, 32'h0, 1, 0);
    run_txn(0, 2'd2, 32'h0000_0101, 32'h0000_1234, 0, 0, 0, 0, 0, 2'b00, 2'b00, 32'h0, 1, 0);
    run_txn(1, 2'd0, 32'h0000_2000, 32'h0, 0, 0, 0, 5, 0, 2'b00, 2'b10, 32'h1234_5678, 0, 1);
    run_txn(1, 2'd3, 32'h0000_0200, 32'hCAFE_F00D, 1, 0, 1, 0, 0, 2'b00, 2'b00, 32'h0, 4, 0);

    // Reset while waiting for read data
    cfg_r_dly = 20; cfg_ar_dly = 0;
    amif.read = 1'b1; amif.write = 2'd0; amif.addr = 32'h0000_3000;
    waited = 0;
    while (!m_rready && waited < 50) begin
      @(negedge clk);
      waited++;
    end
    check_eq("reach_rd_data", 64'(m_rready), 64'd1);
    rst = 1'b1; amif.read = 1'b0;
    @(negedge clk);
    check_eq("midrst_valids", 64'({m_awvalid, m_wvalid, m_bready, m_arvalid, m_rready}), 64'd0);
    check_eq("midrst_ready", 64'({amif.ready, bus_err}), 64'd0);
    check_eq("midrst_load", 64'(amif.load), 64'd0);
    exp_load = '0;
    rst = 1'b0;
    @(negedge clk);
    run_txn(1, 2'd0, 32'h0000_3008, 32'h0, 1, 1, 1, 1, 2, 2'b00, 2'b00, 32'h0BAD_F00D, 0, 0);

    for (int i = 0; i < 40; i++) begin
      wr    = 2'($urandom_range(0, 3));
      rd    = (wr == 2'd0) ? 1'b1 : 1'($urandom_range(0, 1));
      bresp = ($urandom_range(0, 3) == 0) ? 2'($urandom_range(1, 3)) : 2'b00;
      rresp = ($urandom_range(0, 3) == 0) ? 2'($urandom_range(1, 3)) : 2'b00;
      run_txn(rd, wr, $urandom, $urandom,
              int'($urandom_range(0, 3)), int'($urandom_range(0, 3)), int'($urandom_range(0, 3)),
              int'($urandom_range(0, 3)), int'($urandom_range(0, 3)),
              bresp, rresp, $urandom, int'($urandom_range(0, 3)), 1'($urandom_range(0, 1)));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/axi_controller.md
Name: axi_controller

Overview:
- AXI4-Lite master that consumes single-word memory requests from the cache over axi_controller_if (axi_controller modport).
- Issues one AXI4-Lite read or write per request.
- Returns read data and a completion handshake to the cache.
- Sits between the cache and the SoC interconnect; the only bus master on the core's memory side.

Parameters:
AWPROT_VAL, 3'b000, constant driven on AWPROT
ARPROT_VAL, 3'b000, constant driven on ARPROT

Ports:
clk  input  1  system clock, all logic on rising edge
rst  input  1  synchronous active-high reset
amif  interface  -  axi_controller_if.axi_controller (read, write[1:0], addr[31:0], store[31:0], done in; ready, load[31:0] out)
bus_err  output  1  valid while amif.ready=1: 1 = SLVERR/DECERR response or rejected misaligned request
m_awaddr  output  32  write address, word aligned
m_awprot  output  3  AWPROT_VAL
m_awvalid  output  1  write address valid
m_awready  input  1  write address ready
m_wdata  output  32  store data shifted to byte lane
m_wstrb  output  4  byte strobes
m_wvalid  output  1  write data valid
m_wready  input  1  write data ready
m_bresp  input  2  write response
m_bvalid  input  1  write response valid
m_bready  output  1  write response ready
m_araddr  output  32  read address, word aligned
m_arprot  output  3  ARPROT_VAL
m_arvalid  output  1  read address valid
m_arready  input  1  read address ready
m_rdata  input  32  read data
m_rresp  input  2  read response
m_rvalid  input  1  read data valid
m_rready  output  1  read data ready

Behaviour:
- Reset (sync, rst=1 at clock edge): state IDLE; all m_*valid, m_bready, m_rready, ready, bus_err = 0; load = 0; address/data registers = 0.
- Reset mid-transaction: abandons the transaction with no completion. The interconnect shares rst.
- All outputs are registered.
- States: IDLE, WR_REQ, WR_RESP, RD_ADDR, RD_DATA, COMPLETE.
- IDLE, request detection:
  - write!=0 takes priority over read.
  - Capture addr and store on acceptance.
- IDLE, alignment check:
  - Word writes require addr[1:0]=0.
  - Halfword writes require addr[0]=0.
  - A misaligned write makes no bus access: go to COMPLETE with bus_err=1.
  - Reads are always word reads at {addr[31:2],2'b00}; no alignment check.
- Write lanes:
  - byte: wstrb = 4'b0001<<addr[1:0], wdata = {4{store[7:0]}}.
  - halfword: wstrb = 4'b0011<<addr[1:0], wdata = {2{store[15:0]}}.
  - word: wstrb = 4'b1111, wdata = store.
- WR_REQ:
  - Assert m_awvalid and m_wvalid together.
  - Each valid drops independently after its own handshake; track aw_done and w_done.
  - When both are done, go to WR_RESP.
  - Valids never drop before their handshake.
- WR_RESP: m_bready=1. On m_bvalid, bus_err = (m_bresp!=2'b00); go to COMPLETE.
- RD_ADDR: m_arvalid=1 until m_arready, then RD_DATA.
- RD_DATA: m_rready=1. On m_rvalid, load = m_rdata and bus_err = (m_rresp!=2'b00); go to COMPLETE.
  - load updates only on a read completion. Write completions leave it unchanged.
- COMPLETE:
  - ready=1; load and bus_err are held stable.
  - Go to IDLE when done=1, or when read=0 and write=0 (request withdrawn).
  - ready=0 from the next cycle.
- A request present in the same cycle as the exit from COMPLETE is not accepted until the cycle in IDLE.
- Requests are never issued back-to-back without an IDLE cycle.
- Minimum latency, zero-wait slave:
  - Read: request at cycle 0 → ARVALID at 1 → RREADY at 2 → ready at 3.
  - Write: AW/W at 1 → BREADY at 2 → ready at 3.
- Outstanding transactions: at most one at a time; no bursts. AxPROT comes from the parameters.

Decomposition:
- Shared package axi_pkg:
  - axi_resp_t enum (OKAY, EXOKAY, SLVERR, DECERR).
  - axi_ctrl_state_t enum.
  - write-size constants (WR_NONE=0, WR_BYTE=1, WR_HALF=2, WR_WORD=3).
- One sub-module, axi_store_align: purely combinational. Maps (write, addr[1:0], store) to (wdata, wstrb, misaligned).

Test Plan:
- Read, addr=0x0000_1006, zero-wait slave returning 0xDEADBEEF → ARADDR=0x0000_1004; ready at cycle 3; load=0xDEADBEEF; bus_err=0.
- Byte write, addr=0x103, store=0x0000_00A5 → AWADDR=0x100, WSTRB=4'b1000, WDATA=0xA5A5A5A5. Slave accepts AW 3 cycles before W; both valids held until their own handshake; single B handshake.
- Halfword write, addr=0x101 → no AWVALID/WVALID; ready=1 with bus_err=1 at cycle 1; cleared after done.
- Read with RRESP=SLVERR, 5 wait cycles on ARREADY → ARVALID stays high 6 cycles; ready=1 with bus_err=1; load updated.
- write=3 and read=1 simultaneously; done held low 4 cycles after ready → write performed first; ready held 4 cycles; IDLE one cycle after done.
- rst=1 while in RD_DATA → next cycle all valids/readys=0, ready=0, state IDLE; a new read proceeds normally.
